// File: rtl/risc16_pkg.sv
// risc16_pkg: shared opcodes, instruction field positions and fetch FSM encoding for the 16-bit RISC core
package risc16_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OP_LSB  = 12;
    localparam int RS_LSB  = 9;
    localparam int RT_LSB  = 6;
    localparam int RD_LSB  = 3;
    localparam int FN_LSB  = 0;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 6;
    localparam int JT_W    = 12;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: req/ack instruction-memory port between the fetch unit and instruction memory
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
    modport slave (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: next-PC resolution from the issued word; jump beats branch, beq/bne conditions are ORed
module fetch_next_pc
    import risc16_pkg::*;
(
    input  logic [15:0]     pc,
    input  logic [JT_W-1:0] ir,
    input  logic            jump,
    input  logic            beq,
    input  logic            bne,
    input  logic            zero,
    output logic [15:0]     next_pc
);
    logic [15:0] pc2, jump_target, branch_off;
    logic        taken;
    always_comb begin
        pc2         = pc + 16'd2;
        jump_target = {pc2[15:13], ir, 1'b0};
        branch_off  = {{9{ir[IMM_LSB+IMM_W-1]}}, ir[IMM_LSB +: IMM_W], 1'b0};
        taken       = (beq & zero) | (bne & ~zero);
        next_pc     = jump ? jump_target : taken ? pc2 + branch_off : pc2;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and single-outstanding instruction fetcher feeding decode
module instr_fetch_unit
    import risc16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = OP_HALT
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        bus,
    input  logic                      stall,
    input  logic                      jump,
    input  logic                      beq,
    input  logic                      bne,
    input  logic                      zero,
    output logic                      instr_valid,
    output logic [3:0]                opcode,
    output logic [2:0]                rs,
    output logic [2:0]                rt,
    output logic [2:0]                rd,
    output logic [2:0]                funct,
    output logic [5:0]                imm6,
    output logic [15:0]               pc_out,
    output logic                      halted
);
    logic [1:0]  state, state_nxt;
    logic [15:0] pc, ir, next_pc;
    logic        accept, is_halt, load_ir;

    fetch_next_pc u_next_pc (
        .pc      (pc),
        .ir      (ir[JT_W-1:0]),
        .jump    (jump),
        .beq     (beq),
        .bne     (bne),
        .zero    (zero),
        .next_pc (next_pc)
    );

    // control inputs only matter at the accept edge; a halt word never advances the pc
    always_comb begin
        is_halt   = ir[OP_LSB +: 4] == HALT_OP;
        accept    = (state == S_ISSUE) & ~stall;
        load_ir   = (state == S_FETCH) & bus.imem_ack;
        state_nxt = state == S_IDLE  ? S_FETCH :
                    state == S_FETCH ? (bus.imem_ack ? S_ISSUE : S_FETCH) :
                    state == S_ISSUE ? (stall ? S_ISSUE : is_halt ? S_HALT : S_FETCH) :
                    S_HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= (accept & ~is_halt) ? next_pc : pc;
            ir    <= load_ir ? bus.imem_rdata : ir;
        end
    end

    always_comb begin
        bus.imem_req  = state == S_FETCH;
        bus.imem_addr = pc;
        instr_valid   = state == S_ISSUE;
        halted        = state == S_HALT;
        opcode        = ir[OP_LSB +: 4];
        rs            = ir[RS_LSB +: 3];
        rt            = ir[RT_LSB +: 3];
        rd            = ir[RD_LSB +: 3];
        funct         = ir[FN_LSB +: 3];
        imm6          = ir[IMM_LSB +: IMM_W];
        pc_out        = pc;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench; driver queues expected issues, negedge monitor checks them
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, jump = 1'b0, beq = 1'b0, bne = 1'b0, zero = 1'b0;
    logic        instr_valid, halted;
    logic [3:0]  opcode;
    logic [2:0]  rs, rt, rd, funct;
    logic [5:0]  imm6;
    logic [15:0] pc_out;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] w;
    } exp_t;
    exp_t q[$];
    exp_t e_mon;
    logic prev_v = 1'b0;

    instr_fetch_unit_if bus();

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stall       (stall),
        .jump        (jump),
        .beq         (beq),
        .bne         (bne),
        .zero        (zero),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .funct       (funct),
        .imm6        (imm6),
        .pc_out      (pc_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && instr_valid && !prev_v) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual pc=%h op=%h expected none", pc_out, opcode);
            end else begin
                e_mon = q.pop_front();
                chk("issue_pc", pc_out, e_mon.pc);
                chk("issue_opcode", {12'h0, opcode}, {12'h0, e_mon.w[15:12]});
                chk("issue_rs", {13'h0, rs}, {13'h0, e_mon.w[11:9]});
                chk("issue_rt", {13'h0, rt}, {13'h0, e_mon.w[8:6]});
                chk("issue_rd", {13'h0, rd}, {13'h0, e_mon.w[5:3]});
                chk("issue_funct", {13'h0, funct}, {13'h0, e_mon.w[2:0]});
                chk("issue_imm6", {10'h0, imm6}, {10'h0, e_mon.w[5:0]});
            end
        end
        prev_v = instr_valid && !rst;
    end

    // one instruction: wait for req, ack after lat cycles, drive decode inputs, optional stall
    task automatic do_instr(input logic [15:0] w, input int lat, input logic j, input logic b,
                            input logic n, input logic z, input int stl, input logic [15:0] epc);
        int k = 0;
        q.push_back('{pc: epc, w: w});
        while (!bus.imem_req && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("req_seen", {15'h0, bus.imem_req}, 16'h0001);
        chk("fetch_addr", bus.imem_addr, epc);
        for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
            chk("req_hold", {15'h0, bus.imem_req}, 16'h0001);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = w;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'hxxxx;
        jump = j; beq = b; bne = n; zero = z;
        stall = stl > 0;
        for (int i = 0; i < stl; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {15'h0, instr_valid}, 16'h0001);
            chk("stall_noreq", {15'h0, bus.imem_req}, 16'h0000);
            chk("stall_pc", pc_out, epc);
            chk("stall_op", {12'h0, opcode}, {12'h0, w[15:12]});
        end
        stall = 1'b0;
        @(posedge clk); #1;
        jump = 0; beq = 0; bne = 0; zero = 0;
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {15'h0, bus.imem_req}, 16'h0000);
        chk("rst_valid", {15'h0, instr_valid}, 16'h0000);
        chk("rst_halted", {15'h0, halted}, 16'h0000);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_opcode", {12'h0, opcode}, 16'h0000);
        rst = 1'b0;
        chk("idle_req", {15'h0, bus.imem_req}, 16'h0000);
        @(posedge clk); #1;
        chk("first_req", {15'h0, bus.imem_req}, 16'h0001);
        chk("first_addr", bus.imem_addr, 16'h0000);
        do_instr(16'h1234, 0, 0, 0, 0, 0, 0, 16'h0000);
        do_instr(16'h2345, 3, 0, 0, 0, 0, 0, 16'h0002);
        do_instr(16'h6008, 0, 1, 0, 0, 0, 0, 16'h0004);
        do_instr(16'h403F, 1, 0, 1, 0, 1, 0, 16'h0010);
        do_instr(16'h5004, 0, 0, 0, 1, 0, 0, 16'h0010);
        do_instr(16'h403F, 0, 0, 1, 0, 0, 0, 16'h001A);
        do_instr(16'h4002, 0, 0, 1, 1, 0, 0, 16'h001C);
        do_instr(16'h6FFF, 0, 1, 0, 0, 0, 0, 16'h0022);
        do_instr(16'h6FFF, 0, 1, 0, 0, 0, 0, 16'h1FFE);
        do_instr(16'h6FFF, 0, 1, 0, 0, 0, 0, 16'h3FFE);
        do_instr(16'h6FFF, 0, 1, 0, 0, 0, 0, 16'h5FFE);
        do_instr(16'h1000, 0, 0, 0, 0, 0, 0, 16'h7FFE);
        do_instr(16'h6123, 2, 1, 0, 0, 0, 0, 16'h8000);
        do_instr(16'h603F, 0, 1, 1, 0, 1, 0, 16'h8246);
        do_instr(16'h6FFF, 0, 1, 0, 0, 0, 0, 16'h807E);
        do_instr(16'h6FFF, 0, 1, 0, 0, 0, 0, 16'h9FFE);
        do_instr(16'h6FFF, 0, 1, 0, 0, 0, 0, 16'hBFFE);
        do_instr(16'h6FFF, 0, 1, 0, 0, 0, 0, 16'hDFFE);
        do_instr(16'h2A5C, 0, 0, 0, 0, 0, 0, 16'hFFFE);
        do_instr(16'h3B6D, 1, 0, 0, 0, 0, 5, 16'h0000);
        do_instr(16'hF000, 0, 0, 0, 0, 0, 0, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            chk("halt_halted", {15'h0, halted}, 16'h0001);
            chk("halt_noreq", {15'h0, bus.imem_req}, 16'h0000);
            chk("halt_valid", {15'h0, instr_valid}, 16'h0000);
            chk("halt_pc", pc_out, 16'h0002);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("rst_unhalt", {15'h0, halted}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("refetch_req", {15'h0, bus.imem_req}, 16'h0001);
        rst = 1'b1;
        #1;
        chk("async_req_drop", {15'h0, bus.imem_req}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        chk("late_ack_valid", {15'h0, instr_valid}, 16'h0000);
        chk("late_ack_req", {15'h0, bus.imem_req}, 16'h0001);
        chk("late_ack_addr", bus.imem_addr, 16'h0000);
        do_instr(16'h1111, 1, 0, 0, 0, 0, 0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drain", 16'(q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
